// File: rtl/demux_1x4_stream.sv
// rtl/demux_1x4_stream.sv - buffered 1-to-4 stream demultiplexer with per-channel FIFOs and pop counters
//
// Purpose: routes one valid/ready input stream into four output channels by a
// per-word 2-bit select. Each channel owns a 2-entry FIFO and a counter of
// words delivered (popped) on that channel.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready = channel in_sel not full
//   in_data, in_sel       input word and destination channel
//   out_valid[k]          channel k head valid
//   out_ready[k]          consumer k accepts head
//   out_data0..3          channel heads (0 when empty)
//   cnt0..3               delivered-word counters (wrapping)
//   cnt_clr               synchronous clear of all counters, wins over a pop
module demux_1x4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  input  logic             cnt_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  fifo_state_e      state_q [4];
  fifo_state_e      state_d [4];
  logic [WIDTH-1:0] mem_q   [4][2];
  logic [3:0]       wr_ptr_q, wr_ptr_d;
  logic [3:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [WIDTH-1:0] head    [4];
  logic [3:0]       push, pop, full;

  always_comb begin
    full      = '0;
    out_valid = '0;
    push      = '0;
    pop       = '0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      head[k]    = '0;
    end

    for (int k = 0; k < 4; k++) begin
      full[k]      = (state_q[k] == FULL);
      out_valid[k] = (state_q[k] != EMPTY);
    end

    // Readiness looks only at the pre-edge occupancy, so a full channel
    // never takes a word in the cycle it pops (no bypass).
    in_ready = ~full[in_sel];

    for (int k = 0; k < 4; k++) begin
      push[k]     = in_valid & in_ready & (in_sel == 2'(k));
      pop[k]      = out_valid[k] & out_ready[k];
      wr_ptr_d[k] = wr_ptr_q[k] ^ push[k];
      rd_ptr_d[k] = rd_ptr_q[k] ^ pop[k];

      case ({push[k], pop[k]})
        2'b10:   state_d[k] = (state_q[k] == EMPTY) ? ONE : FULL;
        2'b01:   state_d[k] = (state_q[k] == FULL) ? ONE : EMPTY;
        default: state_d[k] = state_q[k];
      endcase

      if (cnt_clr) begin
        cnt_d[k] = '0;
      end else if (pop[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end

      if (state_q[k] != EMPTY) begin
        head[k] = mem_q[k][rd_ptr_q[k]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < 4; k++) begin
        state_q[k]  <= EMPTY;
        cnt_q[k]    <= '0;
        mem_q[k][0] <= '0;
        mem_q[k][1] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        if (push[k]) begin
          mem_q[k][wr_ptr_q[k]] <= in_data;
        end
      end
    end
  end

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb/tb_demux_1x4_stream.sv - self-checking bench for demux_1x4_stream against a queue model
module tb_demux_1x4_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic       cnt_clr;

  logic [7:0] od [4];
  logic [7:0] cn [4];

  // Reference model: one queue per channel plus an unbounded pop tally.
  logic [7:0] mq [4][$];
  int         mcnt [4];
  int         total = 0;
  int         bad = 0;
  string      phase = "reset";

  always #5 clk = ~clk;

  demux_1x4_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .cnt_clr(cnt_clr)
  );

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign cn[0] = cnt0;
  assign cn[1] = cnt1;
  assign cn[2] = cnt2;
  assign cn[3] = cnt3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(mq[in_sel].size() < 2));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
      chk($sformatf("out_data%0d", k), 32'(od[k]), (mq[k].size() != 0) ? 32'(mq[k][0]) : 32'd0);
      chk($sformatf("cnt%0d", k), 32'(cn[k]), 32'(mcnt[k] % 256));
    end
  endtask

  // Drives one cycle: inputs applied after an edge, outputs checked at the
  // falling edge, model advanced at the rising edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d,
                      input logic [3:0] r, input logic c);
    logic acc;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    cnt_clr   = c;
    @(negedge clk);
    check_all();
    acc = v && (mq[s].size() < 2);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0 && r[k]) begin
        void'(mq[k].pop_front());
        mcnt[k]++;
      end
      if (c) mcnt[k] = 0;
    end
    if (acc) mq[s].push_back(d);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mcnt[k] = 0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 8'h00;
    out_ready = 4'h0;
    cnt_clr   = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    phase = "routing";
    step(1, 2'd0, 8'h11, 4'hF, 0);
    step(1, 2'd1, 8'h22, 4'hF, 0);
    step(1, 2'd2, 8'h33, 4'hF, 0);
    step(1, 2'd3, 8'h44, 4'hF, 0);
    step(0, 2'd0, 8'h00, 4'hF, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("route_cnt%0d", k), 32'(cn[k]), 32'd1);

    phase = "backpressure";
    step(1, 2'd1, 8'hA0, 4'b1101, 0);
    step(1, 2'd1, 8'hA1, 4'b1101, 0);
    step(1, 2'd1, 8'hA2, 4'b1101, 0);
    step(1, 2'd1, 8'hA2, 4'b1111, 0);
    step(1, 2'd1, 8'hA2, 4'b1111, 0);
    step(0, 2'd1, 8'h00, 4'b1111, 0);
    step(0, 2'd1, 8'h00, 4'b1111, 0);
    chk("bp_cnt1", 32'(cnt1), 32'd4);

    phase = "pushpop";
    step(1, 2'd3, 8'h5A, 4'b0111, 0);
    step(1, 2'd3, 8'h5B, 4'b1111, 0);
    chk("pp_data3", 32'(out_data3), 32'h5B);
    step(0, 2'd3, 8'h00, 4'b1111, 0);

    phase = "independence";
    step(1, 2'd0, 8'hC0, 4'b1110, 0);
    step(1, 2'd0, 8'hC1, 4'b1110, 0);
    step(0, 2'd0, 8'h00, 4'b1110, 1);
    for (int i = 0; i < 10; i++) step(1, (i % 2 == 0) ? 2'd1 : 2'd2, 8'(8'h60 + i), 4'b1110, 0);
    step(0, 2'd1, 8'h00, 4'b1110, 0);
    chk("ind_cnt1", 32'(cnt1), 32'd5);
    chk("ind_cnt2", 32'(cnt2), 32'd5);
    chk("ind_head0", 32'(out_data0), 32'hC0);

    phase = "counter";
    step(0, 2'd0, 8'h00, 4'b0000, 1);
    for (int i = 0; i < 256; i++) step(1, 2'd0, 8'(i), 4'b1111, 0);
    chk("cnt0_wrap", 32'(cnt0), 32'd0);
    step(0, 2'd0, 8'h00, 4'b0001, 1);
    chk("cnt0_clr_pop", 32'(cnt0), 32'd0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
           4'($urandom), $urandom_range(0, 63) == 0);
    end

    phase = "async_reset";
    step(1, 2'd2, 8'hE0, 4'b0000, 0);
    step(1, 2'd2, 8'hE1, 4'b0000, 0);
    step(1, 2'd2, 8'hE2, 4'b0000, 0);
    in_valid = 1'b0;
    in_sel   = 2'd2;
    rst_n    = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_cnt%0d", k), 32'(cn[k]), 32'd0);
      chk($sformatf("rst_data%0d", k), 32'(od[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 2'd2, 8'h00, 4'b0000, 0);
    step(1, 2'd2, 8'h77, 4'b0100, 0);
    step(0, 2'd2, 8'h00, 4'b0100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
